// File: rtl/alu_share_if.sv
// Requester-side bus of the shared-ALU arbiter: per-requester operation
// requests going in and the shared, registered result bus coming back.
interface alu_share_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [15:0]           resp_y;
  logic [4:0]            resp_status;

  // Requesters (register file / control units) side
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_y, resp_status
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_y, resp_status
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that time-shares one combinational 16-bit ALU among
// NUM_REQ requesters. One operation in flight at a time: IDLE picks a winner,
// EXEC drives the ALU for one cycle and captures its result, RESP holds the
// result for the owner until it is consumed.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_if.slave         bus,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [3:0]         alu_opcode,
  output logic               alu_enable,
  input  logic [15:0]        alu_y,
  input  logic [4:0]         alu_status,
  output logic               busy,
  output logic [15:0]        txn_count
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [15:0]       resp_y_q, resp_y_d;
  logic [4:0]        resp_status_q, resp_status_d;
  logic [15:0]       txn_count_q, txn_count_d;

  logic              found;
  logic [IDXW-1:0]   winner;
  logic [IDXW:0]     cand;
  logic [NUM_REQ-1:0] req_ready_v;
  logic [NUM_REQ-1:0] resp_valid_v;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
      if (!found && bus.req_valid[cand[IDXW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDXW-1:0];
      end
    end
  end

  // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    resp_y_d      = resp_y_q;
    resp_status_d = resp_status_q;
    txn_count_d   = txn_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          a_d      = bus.req_a[{winner, 4'b0000} +: 16];
          b_d      = bus.req_b[{winner, 4'b0000} +: 16];
          op_d     = bus.req_op[{winner, 2'b00} +: 4];
          owner_d  = winner;
          // Winner drops to lowest priority for the next arbitration.
          rr_ptr_d = (winner == IDXW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_y_d      = alu_y;
        resp_status_d = alu_status;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's consume strobe completes the transaction.
        if (bus.resp_ready[owner_q]) begin
          txn_count_d = txn_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; a reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      resp_y_q      <= '0;
      resp_status_q <= '0;
      txn_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      resp_y_q      <= resp_y_d;
      resp_status_q <= resp_status_d;
      txn_count_q   <= txn_count_d;
    end
  end

  // One-hot grant (IDLE only) and one-hot result-available strobes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_ready_v[gi]  = (state_q == ST_IDLE) && found && (winner == IDXW'(gi));
      assign resp_valid_v[gi] = (state_q == ST_RESP) && (owner_q == IDXW'(gi));
    end
  endgenerate

  assign bus.req_ready   = req_ready_v;
  assign bus.resp_valid  = resp_valid_v;
  assign bus.resp_y      = resp_y_q;
  assign bus.resp_status = resp_status_q;

  // Operand registers only change on accept, which always enters EXEC,
  // so outside EXEC the ALU inputs simply hold the last operation.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_enable = (state_q == ST_EXEC);
  assign busy       = (state_q != ST_IDLE);
  assign txn_count  = txn_count_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes hand-computed
// expected responses into a scoreboard queue; a monitor pops and compares
// each time a new resp_valid appears.
module tb_alu_share_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_y, txn_count;
  logic [3:0]  alu_opcode;
  logic [4:0]  alu_status;
  logic        alu_enable, busy;

  always #5 clk = ~clk;

  alu_share_if #(.NUM_REQ(N)) bus ();

  alu_share_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_enable (alu_enable),
    .alu_y      (alu_y),
    .alu_status (alu_status),
    .busy       (busy),
    .txn_count  (txn_count)
  );

  // Stand-in for the shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  logic [16:0] sum17;
  logic [15:0] y_m;
  logic        c_m, v_m;
  always_comb begin
    sum17 = '0;
    y_m   = '0;
    c_m   = 1'b0;
    v_m   = 1'b0;
    case (alu_opcode)
      4'd0: begin
        sum17 = {1'b0, alu_a} + {1'b0, alu_b};
        y_m   = sum17[15:0];
        c_m   = sum17[16];
        v_m   = (alu_a[15] == alu_b[15]) && (y_m[15] != alu_a[15]);
      end
      4'd1: begin
        sum17 = {1'b0, alu_a} - {1'b0, alu_b};
        y_m   = sum17[15:0];
        c_m   = sum17[16];
        v_m   = (alu_a[15] != alu_b[15]) && (y_m[15] != alu_a[15]);
      end
      4'd2: y_m = alu_a & alu_b;
      4'd3: y_m = alu_a | alu_b;
      4'd4: y_m = alu_a ^ alu_b;
      default: y_m = '0;
    endcase
  end
  assign alu_y      = y_m;
  assign alu_status = {^y_m, v_m, y_m[15], (y_m == 16'h0000), c_m};

  typedef struct packed {
    logic [3:0]  owner1h;
    logic [15:0] y;
    logic [4:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
    bus.req_op[4*i +: 4]  = op;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic expect_resp(input int i, input logic [15:0] y, input logic [4:0] st);
    exp_t e;
    e.owner1h = 4'(1 << i);
    e.y       = y;
    e.st      = st;
    sb_q.push_back(e);
  endtask

  // Wait for n grants; optionally drop each granted requester's valid.
  task automatic run_grants(input int n, input bit drop);
    int         got;
    int         budget;
    logic [3:0] g;
    got    = 0;
    budget = 0;
    while (got < n && budget < 200) begin
      @(negedge clk);
      budget++;
      g = bus.req_ready;
      if (g != 4'b0000) begin
        got++;
        @(posedge clk);
        #1;
        if (drop) bus.req_valid = bus.req_valid & ~g;
      end
    end
    chk("grant_count", got, n);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (busy && budget < 100);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare each newly presented response against the scoreboard.
  initial begin : monitor
    exp_t       e;
    logic [3:0] prev_rv;
    prev_rv = '0;
    forever begin
      @(negedge clk);
      if (bus.resp_valid != 4'b0000 && prev_rv == 4'b0000) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid 0x%0h required none", bus.resp_valid);
        end else begin
          e = sb_q.pop_front();
          chk("resp_owner", bus.resp_valid, e.owner1h);
          chk("resp_y", bus.resp_y, e.y);
          chk("resp_status", bus.resp_status, e.st);
          $display("txn owner=%b y=0x%04h status=%b", bus.resp_valid, bus.resp_y, bus.resp_status);
        end
      end
      prev_rv = bus.resp_valid;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = '1;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_alu_enable", {31'd0, alu_enable}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_y", bus.resp_y, 0);
    chk("rst_txn_count", txn_count, 0);
    rst_n = 1'b1;

    // Single ADD on req0, cycle-accurate latency
    @(posedge clk); #1;
    set_req(0, 16'h7FFF, 16'h0001, 4'd0);
    expect_resp(0, 16'h8000, 5'h1C);
    @(negedge clk);
    chk("t1_req_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_alu_enable", {31'd0, alu_enable}, 1);
    chk("t1_alu_a", alu_a, 16'h7FFF);
    chk("t1_alu_b", alu_b, 16'h0001);
    chk("t1_alu_opcode", alu_opcode, 0);
    chk("t1_resp_valid_early", bus.resp_valid, 0);
    @(negedge clk);
    chk("t1_resp_valid", bus.resp_valid, 4'b0001);
    chk("t1_enable_off", {31'd0, alu_enable}, 0);
    chk("t1_txn_before", txn_count, 0);
    @(posedge clk); #1;
    chk("t1_txn_after", txn_count, 1);
    chk("t1_busy", {31'd0, busy}, 0);

    // SUB on req3; resp_ready from non-owner req2 ignored
    bus.resp_ready = 4'b0100;
    set_req(3, 16'h0000, 16'h0001, 4'd1);
    expect_resp(3, 16'hFFFF, 5'h05);
    run_grants(1, 1'b1);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t6_resp_valid_held", bus.resp_valid, 4'b1000);
    chk("t6_txn_held", txn_count, 1);
    bus.resp_ready = 4'b1000;
    @(posedge clk); #1;
    chk("t6_txn_after", txn_count, 2);
    bus.resp_ready = '1;

    // All four valid continuously: grant order 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 16'hF0F0, 16'h0FF0, 4'd2);
    expect_resp(0, 16'h00F0, 5'h00);
    expect_resp(1, 16'h00F0, 5'h00);
    expect_resp(2, 16'h00F0, 5'h00);
    expect_resp(3, 16'h00F0, 5'h00);
    expect_resp(0, 16'h00F0, 5'h00);
    run_grants(5, 1'b0);
    bus.req_valid = '0;
    wait_idle();
    chk("t2_txn", txn_count, 7);

    // Backpressure: owner req0 withholds resp_ready, req1 must wait
    @(posedge clk); #1;
    set_req(0, 16'h1200, 16'h0034, 4'd3);
    expect_resp(0, 16'h1234, 5'h10);
    run_grants(1, 1'b1);
    set_req(1, 16'hAAAA, 16'h5555, 4'd4);
    expect_resp(1, 16'hFFFF, 5'h04);
    bus.resp_ready[0] = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t3_resp_valid", bus.resp_valid, 4'b0001);
      chk("t3_resp_y", bus.resp_y, 16'h1234);
      chk("t3_req_ready", bus.req_ready, 4'b0000);
      chk("t3_alu_enable", {31'd0, alu_enable}, 0);
    end
    bus.resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_req1_ready", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    wait_idle();
    chk("t3_txn", txn_count, 9);

    // Mixed ops, all valid, rr_ptr=2: grant order 2,3,0,1
    @(posedge clk); #1;
    set_req(0, 16'hFFFF, 16'h0001, 4'd0);
    set_req(1, 16'h8000, 16'h0001, 4'd1);
    set_req(2, 16'h0F00, 16'h00F0, 4'd3);
    set_req(3, 16'h1234, 16'h1234, 4'd4);
    expect_resp(2, 16'h0FF0, 5'h00);
    expect_resp(3, 16'h0000, 5'h02);
    expect_resp(0, 16'h0000, 5'h03);
    expect_resp(1, 16'h7FFF, 5'h18);
    run_grants(4, 1'b1);
    wait_idle();
    chk("t7_txn", txn_count, 13);

    // Reset during EXEC drops the transaction and rr_ptr
    @(posedge clk); #1;
    set_req(2, 16'h1111, 16'h2222, 4'd0);
    run_grants(1, 1'b1);
    chk("t4_in_exec", {31'd0, alu_enable}, 1);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_alu_enable", {31'd0, alu_enable}, 0);
    chk("t4_alu_a", alu_a, 0);
    chk("t4_resp_y", bus.resp_y, 0);
    chk("t4_resp_valid", bus.resp_valid, 0);
    chk("t4_txn", txn_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1, 16'h0001, 16'h0002, 4'd0);
    set_req(3, 16'hFFFF, 16'h8001, 4'd2);
    expect_resp(1, 16'h0003, 5'h00);
    expect_resp(3, 16'h8001, 5'h04);
    @(negedge clk);
    chk("t4_rr_ptr_zero", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    run_grants(1, 1'b1);
    wait_idle();
    chk("t4_txn_after", txn_count, 2);

    // txn_count wrap
    @(negedge clk);
    force dut.txn_count_q = 16'hFFFE;
    #1;
    release dut.txn_count_q;
    #1;
    chk("t5_preset", txn_count, 16'hFFFE);
    @(posedge clk); #1;
    set_req(0, 16'h0000, 16'h0000, 4'd3);
    expect_resp(0, 16'h0000, 5'h02);
    run_grants(1, 1'b1);
    wait_idle();
    chk("t5_ffff", txn_count, 16'hFFFF);
    @(posedge clk); #1;
    set_req(0, 16'h0000, 16'h0000, 4'd3);
    expect_resp(0, 16'h0000, 5'h02);
    run_grants(1, 1'b1);
    wait_idle();
    chk("t5_wrap", txn_count, 16'h0000);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
